// File: rtl/mips_multicycle_control.sv
// rtl/mips_multicycle_control.sv - multicycle MIPS main control FSM with memory timeout and retire counter
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             memReady,
  output logic [5:0]       ALUOP,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       PCSource,
  output logic             pcWrite,
  output logic             IorD,
  output logic             memRead,
  output logic             memWrite,
  output logic             irWrite,
  output logic             regWrite,
  output logic             regDst,
  output logic             memToReg,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instrCount,
  output logic             error,
  output logic [1:0]       errCode
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_MEMADR = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_MEMWB  = 4'd5;
  localparam logic [3:0] S_MEMWR  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_ERROR  = 4'd15;

  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [5:0] OP_SUB = 6'b000001;
  localparam logic [5:0] OP_RT  = 6'b000010;

  // Counter only needs to reach MEM_TIMEOUT-1; it never counts past the hit value.
  localparam int         TW      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

  logic [3:0]       r_state;
  logic [TW-1:0]    r_tcnt;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_err_code;
  logic [3:0]       w_next;
  logic             w_wait;
  logic             w_to_hit;
  logic             w_retire;

  assign w_wait   = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_to_hit = (MEM_TIMEOUT != 0) && w_wait && !memReady && (r_tcnt == TO_LAST);
  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BRANCH) ||
                    (r_state == S_ADDIWB) || (r_state == S_JUMP) ||
                    ((r_state == S_MEMWR) && memReady);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = memReady ? S_DECODE : (w_to_hit ? S_ERROR : S_FETCH);
      S_DECODE: begin
        case (opcode)
          6'b000000:           w_next = S_EXEC;
          6'b100011, 6'b101011: w_next = S_MEMADR;
          6'b000100:           w_next = S_BRANCH;
          6'b001000:           w_next = S_ADDIEX;
          6'b000010:           w_next = S_JUMP;
          default:             w_next = S_ERROR;
        endcase
      end
      S_MEMADR: w_next = (opcode == 6'b101011) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  w_next = memReady ? S_MEMWB : (w_to_hit ? S_ERROR : S_MEMRD);
      S_MEMWR:  w_next = memReady ? S_FETCH : (w_to_hit ? S_ERROR : S_MEMWR);
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: w_next = S_FETCH;
      S_ERROR:  w_next = S_ERROR;
      default:  w_next = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_tcnt     <= '0;
      r_count    <= '0;
      r_err_code <= 2'b00;
    end else begin
      r_state <= w_next;
      r_tcnt  <= (w_wait && !memReady && !w_to_hit) ? r_tcnt + TW'(1) : '0;
      if (w_retire)
        r_count <= r_count + CNT_W'(1);
      if ((w_next == S_ERROR) && (r_state != S_ERROR))
        r_err_code <= w_to_hit ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    ALUOP    = OP_ADD;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSource = 2'b00;
    pcWrite  = 1'b0;
    IorD     = 1'b0;
    memRead  = 1'b0;
    memWrite = 1'b0;
    irWrite  = 1'b0;
    regWrite = 1'b0;
    regDst   = 1'b0;
    memToReg = 1'b0;
    case (r_state)
      S_FETCH: begin
        memRead = 1'b1;
        ALUSrcB = 2'b01;
        irWrite = memReady;
        pcWrite = memReady;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR, S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        memRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        regWrite = 1'b1;
        memToReg = 1'b1;
      end
      S_MEMWR: begin
        memWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOP   = OP_RT;
      end
      S_ALUWB: begin
        regWrite = 1'b1;
        regDst   = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        ALUOP    = OP_SUB;
        PCSource = 2'b01;
        pcWrite  = zero;
      end
      S_ADDIWB: regWrite = 1'b1;
      S_JUMP: begin
        PCSource = 2'b10;
        pcWrite  = 1'b1;
      end
      default: ;
    endcase
  end

  assign state      = r_state;
  assign instrCount = r_count;
  assign error      = (r_state == S_ERROR);
  assign errCode    = r_err_code;

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM of the multicycle MIPS core.
- Sits directly upstream of the ALU-control stage: drives its 6-bit ALUOP and the datapath mux selects and write enables.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Handshakes with unified memory via memReady, enforces a memory timeout, and counts retired instructions.

Parameters:
- MEM_TIMEOUT, 255, consecutive memReady-low cycles tolerated in a wait state before error; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- opcode  in  6  instruction register bits [31:26].
- zero  in  1  ALU zero flag.
- memReady  in  1  memory access complete this cycle.
- ALUOP  out  6  to ALU control: 000000 add, 000001 sub, 000010 R-type (decode funct).
- ALUSrcA  out  1  0=PC, 1=register A.
- ALUSrcB  out  2  00=register B, 01=constant 4, 10=sign-extended imm, 11=imm<<2.
- PCSource  out  2  00=ALU result, 01=ALUOut register, 10=jump target.
- pcWrite  out  1  PC write enable.
- IorD  out  1  memory address: 0=PC, 1=ALUOut.
- memRead  out  1  memory read request.
- memWrite  out  1  memory write request.
- irWrite  out  1  instruction register load.
- regWrite  out  1  register file write.
- regDst  out  1  0=rt, 1=rd.
- memToReg  out  1  0=ALUOut, 1=memory data register.
- state  out  4  current state encoding, for debug.
- instrCount  out  CNT_W  retired-instruction count.
- error  out  1  sticky error flag.
- errCode  out  2  01 illegal opcode, 10 memory timeout, 00 none.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE(0), instrCount=0, error=0, errCode=00, timeout counter=0.
  - All control outputs are 0 (ALUOP=000000).
- Outputs are Moore-decoded from state, except the memReady/zero qualifiers listed below. Outputs not named in a state are 0.
- State encodings and behaviour:
  - IDLE(0): all outputs 0. Next is FETCH unconditionally; one cycle after reset release.
  - FETCH(1): memRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=add, PCSource=00. irWrite=pcWrite=memReady. Stays until memReady=1, then DECODE.
  - DECODE(2): ALUSrcA=0, ALUSrcB=11, ALUOP=add. Next state by opcode:
    - 000000 → EXEC
    - 100011 or 101011 → MEMADR
    - 000100 → BRANCH
    - 001000 → ADDIEX
    - 000010 → JUMP
    - other → ERROR with errCode=01
  - MEMADR(3): ALUSrcA=1, ALUSrcB=10, ALUOP=add. Next is MEMRD for lw, MEMWR for sw.
  - MEMRD(4): memRead=1, IorD=1. Waits for memReady, then MEMWB.
  - MEMWB(5): regWrite=1, memToReg=1, regDst=0. Next FETCH. Retires.
  - MEMWR(6): memWrite=1, IorD=1. Waits for memReady, then FETCH. Retires on the exit edge.
  - EXEC(7): ALUSrcA=1, ALUSrcB=00, ALUOP=R-type. Next ALUWB.
  - ALUWB(8): regWrite=1, regDst=1. Next FETCH. Retires.
  - BRANCH(9): ALUSrcA=1, ALUSrcB=00, ALUOP=sub, PCSource=01, pcWrite=zero. Next FETCH. Retires whether taken or not.
  - ADDIEX(10): ALUSrcA=1, ALUSrcB=10, ALUOP=add. Next ADDIWB.
  - ADDIWB(11): regWrite=1, regDst=0. Next FETCH. Retires.
  - JUMP(12): PCSource=10, pcWrite=1. Next FETCH. Retires.
  - ERROR(15): all control outputs 0, error=1. Sticky until reset.
- Retire: instrCount increments on the clock edge leaving a retiring state. Wraps at 2^CNT_W to 0.
- Timeout:
  - Counter increments each cycle in FETCH/MEMRD/MEMWR with memReady=0. It clears on any state change or when memReady=1.
  - When the counter equals MEM_TIMEOUT-1 and memReady=0, the next state is ERROR with errCode=10.
  - memReady=1 on that same cycle wins: normal transition, no error.
- errCode is written only on entry to ERROR; the first error is retained.
- Reset asserted mid-instruction: immediate return to IDLE. A partially completed instruction is not counted.
- Lookahead in DECODE/MEMADR/EXEC states is 0; each state occupies exactly one cycle unless waiting on memReady.

Test Plan:
- Release reset, memReady=1 constant, opcode=000000 → state sequence 0,1,2,7,8,1. ALUOP=000010 in EXEC. regWrite=1, regDst=1 in ALUWB. instrCount=1 after ALUWB.
- lw (100011) with memReady low for 3 cycles in MEMRD → MEMRD held 4 cycles. memRead=1, IorD=1 throughout. MEMWB asserts regWrite and memToReg. instrCount increments by 1.
- beq (000100): first with zero=1 → pcWrite=1, PCSource=01, ALUOP=000001 in BRANCH. Then with zero=0 → pcWrite=0. instrCount still increments by 1 each time.
- MEM_TIMEOUT=4, memReady held 0 in FETCH → ERROR after 4 waiting cycles, error=1, errCode=10. Stays in ERROR until reset. In a second run, memReady=1 on the 4th cycle → DECODE, no error.
- opcode=111111 in DECODE → ERROR, errCode=01, all control outputs 0.
- Assert reset during MEMWR → outputs 0 immediately and instrCount=0. After release, sequence is IDLE then FETCH.
